fib_sequencer: RTL and testbench
================================

FIB_SEQUENCER -- requirements
Module: fib_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock for state, counter and input sampling.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request to compute F(n), sampled in IDLE only.
REQ-004 SHALL have port n, input, 5 bits: Fibonacci index, unsigned.
REQ-005 SHALL have port immediate, output, 16 bits: constant driven to the datapath immediate path.
REQ-006 SHALL have port enable, output, 16 bits: one-hot register-file write enable; bit k writes rk.
REQ-007 SHALL have port control1 / control2, output, 5 bits each: left/right operand register index in [3:0]; bit 4 is always 0.
REQ-008 SHALL have port imm_control, output, 1 bit: 1 selects immediate in place of the right operand.
REQ-009 SHALL have port opcode, output, 8 bits: ALU operation.
REQ-010 SHALL have port buff_en, output, 1 bit: ALU-output tristate enable onto the write bus.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1 bit: valid with done; 1 means n > 24.
REQ-014 SHALL have port result_sel, output, 4 bits: register index holding F(n); valid with done and held until the next start.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, LD0, LD1, ADD, MOV0, MOV1 and DONE; the state register updates on posedge clk, and outputs decode from the current state only.
REQ-016 IDLE: all datapath outputs 0; start=1 SHALL go to DONE if n>24, otherwise to LD0, and latch n into an internal register.
REQ-017 LD0 SHALL write r0 <= 0: opcode=OP_PASSB, imm_control=1, immediate=0, enable=16'h0001, buff_en=1.
REQ-018 LD1 SHALL write r1 <= 1: OP_PASSB, imm_control=1, immediate=1, enable=16'h0002, buff_en=1.
REQ-019 After LD1, latched n<2 SHALL go to DONE with result_sel=n; otherwise go to ADD with iteration counter cleared to 0.
REQ-020 ADD SHALL write r2 <= r0+r1: OP_ADD, control1=0, control2=1, imm_control=0, enable=16'h0004, buff_en=1.
REQ-021 MOV0 SHALL write r0 <= r1: OP_PASSB, control2=1, enable=16'h0001, buff_en=1.
REQ-022 MOV1 SHALL write r1 <= r2: OP_PASSB, control2=2, enable=16'h0002, buff_en=1, and increment the counter.
REQ-023 MOV1 SHALL go to DONE with result_sel=1 when counter+1 == latched n-1; otherwise it SHALL go to ADD.
REQ-024 DONE SHALL drive done=1, drive all datapath outputs to 0, and go to IDLE unconditionally.
REQ-025 Latency from the start-sampling edge to done high SHALL be 3 cycles for n in {0,1}, 3*n cycles for 2<=n<=24, and 1 cycle for n>24.
REQ-026 start while busy SHALL be ignored; changes on n while busy SHALL have no effect.
REQ-027 Arithmetic SHALL be 16-bit unsigned; n<=24 keeps F(n)<=46368, so no overflow is possible.
REQ-028 Every write enable SHALL be one-hot or zero, and buff_en SHALL equal |enable in every state.

Reset
REQ-029 reset low SHALL force IDLE immediately and clear the counter, latched n, result_sel, done, err and all datapath outputs to 0, including mid-sequence.
REQ-030 After reset release, the first start SHALL behave as from a cold IDLE.

Structure
REQ-031 A shared package SHALL hold the state encoding (4-bit), OP_ADD=8'h05, OP_PASSB=8'h0D, register indices R0..R2, and FIB_NMAX=24.
REQ-032 The output decode SHALL be a single sub-module, fib_seq_decode (state -> datapath control word); the counter and next-state logic stay in the top module.

Verification
REQ-033 n=0, start pulse -> LD0, LD1, DONE; done high at cycle 3; result_sel=0; err=0.
REQ-034 n=2 -> enable sequence 0001, 0002, 0004, 0001, 0002; done at cycle 6; result_sel=1; a datapath model shows r1=1.
REQ-035 n=10 -> done at cycle 30; the datapath model shows r1=55; err=0.
REQ-036 n=24 -> done at cycle 72 with r1=46368; n=25 -> done at cycle 1 with err=1, enable=0 throughout.
REQ-037 Reset asserted in ADD during an n=10 run -> all outputs 0 asynchronously; a subsequent n=3 start gives done at cycle 9 with r1=2.
REQ-038 start re-asserted while busy with a different n -> the original run completes unchanged with the original latency.

Source files
------------

// File: rtl/fib_sequencer_pkg.sv
// rtl/fib_sequencer_pkg.sv - shared state encoding, opcodes and register indices for fib_sequencer
package fib_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LD0  = 4'd1,
        S_LD1  = 4'd2,
        S_ADD  = 4'd3,
        S_MOV0 = 4'd4,
        S_MOV1 = 4'd5,
        S_DONE = 4'd6
    } state_t;

    localparam logic [7:0] OP_ADD   = 8'h05;
    localparam logic [7:0] OP_PASSB = 8'h0D;

    localparam logic [4:0] R0 = 5'd0;
    localparam logic [4:0] R1 = 5'd1;
    localparam logic [4:0] R2 = 5'd2;

    // Largest index whose Fibonacci value still fits in 16 bits unsigned
    localparam logic [4:0] FIB_NMAX = 5'd24;

endpackage

// File: rtl/fib_sequencer_if.sv
// rtl/fib_sequencer_if.sv - request and datapath-control signal bundle for fib_sequencer
interface fib_sequencer_if;
    logic        start;
    logic [4:0]  n;
    logic [15:0] immediate;
    logic [15:0] enable;
    logic [4:0]  control1;
    logic [4:0]  control2;
    logic        imm_control;
    logic [7:0]  opcode;
    logic        buff_en;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  result_sel;

    modport master (
        output start, n,
        input  immediate, enable, control1, control2, imm_control, opcode,
               buff_en, busy, done, err, result_sel
    );

    modport slave (
        input  start, n,
        output immediate, enable, control1, control2, imm_control, opcode,
               buff_en, busy, done, err, result_sel
    );
endinterface

// File: rtl/fib_seq_decode.sv
// rtl/fib_seq_decode.sv - Moore decode from sequencer state to datapath control word
module fib_seq_decode
    import fib_sequencer_pkg::*;
(
    input  state_t      state,
    output logic [15:0] immediate,
    output logic [15:0] enable,
    output logic [4:0]  control1,
    output logic [4:0]  control2,
    output logic        imm_control,
    output logic [7:0]  opcode,
    output logic        buff_en,
    output logic        busy,
    output logic        done
);

    always_comb begin
        immediate   = 16'h0000;
        enable      = 16'h0000;
        control1    = 5'd0;
        control2    = 5'd0;
        imm_control = 1'b0;
        opcode      = 8'h00;
        case (state)
            S_LD0: begin
                opcode      = OP_PASSB;
                imm_control = 1'b1;
                immediate   = 16'd0;
                enable      = 16'h0001;
            end
            S_LD1: begin
                opcode      = OP_PASSB;
                imm_control = 1'b1;
                immediate   = 16'd1;
                enable      = 16'h0002;
            end
            S_ADD: begin
                opcode   = OP_ADD;
                control1 = R0;
                control2 = R1;
                enable   = 16'h0004;
            end
            S_MOV0: begin
                opcode   = OP_PASSB;
                control2 = R1;
                enable   = 16'h0001;
            end
            S_MOV1: begin
                opcode   = OP_PASSB;
                control2 = R2;
                enable   = 16'h0002;
            end
            default: ;
        endcase
    end

    // The ALU only drives the write bus when some register is being written
    assign buff_en = |enable;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

endmodule

// File: rtl/fib_sequencer.sv
// rtl/fib_sequencer.sv - FSM sequencing a register-file datapath to compute F(n)
module fib_sequencer
    import fib_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    fib_sequencer_if.slave  bus
);

    state_t     state;
    logic [4:0] n_lat;
    logic [4:0] count;
    logic       err_q;
    logic [3:0] result_sel_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            n_lat        <= 5'd0;
            count        <= 5'd0;
            err_q        <= 1'b0;
            result_sel_q <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        n_lat        <= bus.n;
                        count        <= 5'd0;
                        result_sel_q <= 4'd0;
                        err_q        <= (bus.n > FIB_NMAX);
                        state        <= (bus.n > FIB_NMAX) ? S_DONE : S_LD0;
                    end
                end
                S_LD0: state <= S_LD1;
                S_LD1: begin
                    // F(0) and F(1) are already sitting in r0 and r1
                    if (n_lat < 5'd2) begin
                        result_sel_q <= n_lat[3:0];
                        state        <= S_DONE;
                    end else begin
                        count <= 5'd0;
                        state <= S_ADD;
                    end
                end
                S_ADD:  state <= S_MOV0;
                S_MOV0: state <= S_MOV1;
                S_MOV1: begin
                    count <= count + 5'd1;
                    if (count + 5'd1 == n_lat - 5'd1) begin
                        result_sel_q <= R1[3:0];
                        state        <= S_DONE;
                    end else begin
                        state <= S_ADD;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    fib_seq_decode u_decode (
        .state       (state),
        .immediate   (bus.immediate),
        .enable      (bus.enable),
        .control1    (bus.control1),
        .control2    (bus.control2),
        .imm_control (bus.imm_control),
        .opcode      (bus.opcode),
        .buff_en     (bus.buff_en),
        .busy        (bus.busy),
        .done        (bus.done)
    );

    assign bus.err        = err_q;
    assign bus.result_sel = result_sel_q;

endmodule

// File: tb/tb_fib_sequencer.sv
// tb/tb_fib_sequencer.sv - directed self-checking bench for fib_sequencer with a register-file model
module tb_fib_sequencer;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    fib_sequencer_if bus ();

    fib_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: 16 x 16-bit register file written through the ALU
    logic [15:0] rf [16];
    logic [15:0] alu_l, alu_r, alu_v;
    logic [15:0] en_log [$];
    bit          en_seen;
    bit          bus_bad;

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 16'h0;
        en_seen = 1'b0;
        bus_bad = 1'b0;
    end

    always @(negedge clk) begin
        if (reset) begin
            if ($countones(bus.enable) > 1 || bus.buff_en !== (|bus.enable))
                bus_bad = 1'b1;
            if (bus.enable != 16'h0) begin
                en_seen = 1'b1;
                en_log.push_back(bus.enable);
            end
            if (bus.buff_en) begin
                alu_l = rf[bus.control1[3:0]];
                alu_r = bus.imm_control ? bus.immediate : rf[bus.control2[3:0]];
                if (bus.opcode == 8'h05)      alu_v = alu_l + alu_r;
                else if (bus.opcode == 8'h0D) alu_v = alu_r;
                else                          alu_v = 16'hDEAD;
                for (int k = 0; k < 16; k++)
                    if (bus.enable[k]) rf[k] = alu_v;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts a run on the next edge and returns edges from the sampling edge until done is seen
    task automatic run(input logic [4:0] nv, input bit interfere, output int lat);
        @(negedge clk);
        en_log.delete();
        en_seen  = 1'b0;
        bus.n     = nv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        lat = 1;
        if (interfere) bus.n = 5'd5;
        else           bus.start = 1'b0;
        while (bus.done !== 1'b1 && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
            if (interfere && lat == 8) begin
                bus.start = 1'b0;
                bus.n     = nv;
            end
        end
    endtask

    task automatic after_done(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
    endtask

    int          lat;
    int          k;
    logic [15:0] exp_seq [5];

    initial begin
        exp_seq[0] = 16'h0001; exp_seq[1] = 16'h0002; exp_seq[2] = 16'h0004;
        exp_seq[3] = 16'h0001; exp_seq[4] = 16'h0002;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.n     = 5'd0;
        #12;
        check("reset_enable", bus.enable, 16'h0);
        check("reset_flags", {bus.busy, bus.done, bus.err, bus.buff_en, bus.result_sel}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run(5'd0, 1'b0, lat);
        check("n0_latency", lat, 3);
        check("n0_result_sel", bus.result_sel, 0);
        check("n0_err", bus.err, 0);
        after_done("n0");

        run(5'd1, 1'b0, lat);
        check("n1_latency", lat, 3);
        check("n1_result_sel", bus.result_sel, 1);
        check("n1_r1", rf[1], 1);
        after_done("n1");

        run(5'd2, 1'b0, lat);
        check("n2_latency", lat, 6);
        check("n2_result_sel", bus.result_sel, 1);
        check("n2_r1", rf[1], 1);
        check("n2_en_count", en_log.size(), 5);
        if (en_log.size() == 5)
            for (int i = 0; i < 5; i++) check("n2_en_seq", en_log[i], exp_seq[i]);
        after_done("n2");

        run(5'd10, 1'b0, lat);
        check("n10_latency", lat, 30);
        check("n10_r1", rf[1], 55);
        check("n10_err", bus.err, 0);
        after_done("n10");

        run(5'd24, 1'b0, lat);
        check("n24_latency", lat, 72);
        check("n24_r1", rf[1], 46368);
        check("n24_result_sel", bus.result_sel, 1);
        after_done("n24");

        run(5'd25, 1'b0, lat);
        check("n25_latency", lat, 1);
        check("n25_err", bus.err, 1);
        check("n25_no_enable", en_seen, 0);
        after_done("n25");

        // Asynchronous reset while in ADD during an n=10 run
        @(negedge clk);
        bus.n     = 5'd10;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        k = 0;
        while (bus.enable !== 16'h0004 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("rst_reached_add", bus.enable, 16'h0004);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_word", {bus.immediate, bus.enable}, 32'd0);
        check("rst_async_ctl", {bus.control1, bus.control2, bus.imm_control, bus.opcode}, 32'd0);
        check("rst_async_flags", {bus.busy, bus.done, bus.err, bus.buff_en, bus.result_sel}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run(5'd3, 1'b0, lat);
        check("n3_latency", lat, 9);
        check("n3_r1", rf[1], 2);
        after_done("n3");

        run(5'd10, 1'b1, lat);
        check("busy_start_latency", lat, 30);
        check("busy_start_r1", rf[1], 55);
        check("busy_start_result_sel", bus.result_sel, 1);
        after_done("busy_start");

        check("onehot_buff_en", bus_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
